pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline: PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Combines four event sources into one per-stage stall vector, a flush strobe and a PC redirect:
  - load-use stall requests from ID,
  - multi-cycle EX operations (mult/div),
  - taken branches resolved in ID,
  - exceptions raised in MEM.
- Owns a small FSM and down-counter that holds EX for the duration of a multi-cycle op.

Parameters:
- PC_W, 32, width of PC and redirect target.
- MC_CNT_W, 5, width of the multi-cycle length field; max length 2^MC_CNT_W-1.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- id_stallreq  input  1  ID operand not ready (load-use).
- id_branch_taken  input  1  branch in ID resolved taken.
- id_branch_target  input  PC_W  branch target.
- ex_mc_start  input  1  EX begins a multi-cycle op this cycle; single-cycle pulse.
- ex_mc_len  input  MC_CNT_W  op length L, in stall cycles.
- mem_excp  input  1  exception in MEM.
- mem_excp_vector  input  PC_W  handler address.
- stall  output  6  bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB.
- flush  output  1  clear all pipeline registers.
- flush_if_id  output  1  clear IF/ID only.
- pc_redirect  output  1  load redirect_pc into PC.
- redirect_pc  output  PC_W  next PC when pc_redirect=1.
- ex_mc_done  output  1  registered; multi-cycle result valid in EX this cycle.

Behaviour:
- Stall semantics (consumed by stage registers):
  - stall[i]=1 and stall[i+1]=1: stage i register holds.
  - stall[i]=1 and stall[i+1]=0: stage i inserts a bubble (zero word).
- Reset, while rst=1 regardless of inputs:
  - state=IDLE, counter=0, ex_mc_done=0.
  - stall=0, flush=0, flush_if_id=0, pc_redirect=0, redirect_pc=0.
- Reset mid multi-cycle op aborts to IDLE on the next edge. No done pulse.
- FSM states IDLE, BUSY, DONE; state and counter registered, all other outputs combinational.
- IDLE:
  - ex_mc_start=1 with L>=2: stall=6'b001111, counter<=L-2, go to BUSY.
  - ex_mc_start=1 with L=1: stall=6'b001111 this cycle only, go to DONE.
  - L=0: ignored; no stall, no transition.
- BUSY:
  - stall=6'b001111 every cycle.
  - counter==0: go to DONE; else counter decrements.
- DONE:
  - ex_mc_done=1, no mc stall, go to IDLE.
  - ex_mc_start in DONE is honoured exactly as in IDLE; back-to-back ops are allowed.
- Total EX hold for length L is exactly L cycles (start cycle plus BUSY cycles). The result is consumed in the DONE cycle.
- ex_mc_start while BUSY is ignored; EX is frozen, so it cannot legitimately occur.
- Load-use: id_stallreq=1 with no higher-priority event gives stall=6'b000111 (bubble into ID/EX).
- Branch: id_branch_taken=1, no higher event, id_stallreq=0:
  - pc_redirect=1, redirect_pc=id_branch_target, flush_if_id=1, stall=0.
- Priority (highest first), one source acts per cycle:
  1. mem_excp
  2. mc stall (start cycle or BUSY)
  3. id_stallreq
  4. id_branch_taken
- Branch with id_stallreq=1 is suppressed: operands are stale, so it is re-evaluated next cycle.
- Branch during a mc stall is suppressed: ID is held, so the branch is re-presented later.
- Exception:
  - flush=1, flush_if_id=1, pc_redirect=1, redirect_pc=mem_excp_vector, stall=0.
  - FSM forced to IDLE on the next edge, counter cleared, no ex_mc_done.
  - Exception in the same cycle as ex_mc_start: start ignored.
- Counter width arithmetic is unsigned. L=2^MC_CNT_W-1 must work without wrap.

Decomposition:
- Shared defines: stall vector encodings STALL_NONE=6'b000000, STALL_ID=6'b000111, STALL_EX=6'b001111; FSM state encodings MC_IDLE/MC_BUSY/MC_DONE.
- Constants RstEnable and ZeroWord come from the existing defines.
- One natural sub-module, mc_stall_timer: FSM plus counter, outputs mc_stall and ex_mc_done, with an abort input. The top level does the priority mux.

Test Plan:
1. Reset: assert rst with all inputs high for 3 cycles -> all outputs 0; state IDLE after release.
2. Multi-cycle: ex_mc_start, L=4 -> stall=001111 for exactly 4 cycles, ex_mc_done=1 on the 5th, stall=0 on the 5th; L=1 -> 1 stall cycle then done; L=0 -> no stall, no done; L=31 -> 31 stall cycles.
3. Load-use plus branch: id_stallreq=1 and id_branch_taken=1, target 0x00000040 -> stall=000111, pc_redirect=0. Next cycle id_stallreq=0 -> pc_redirect=1, redirect_pc=0x40, flush_if_id=1.
4. Branch during mc: L=3 with id_branch_taken held high -> no redirect for 3 cycles; redirect in the DONE cycle.
5. Exception abort: L=6, mem_excp=1 with vector 0x00000180 in the 3rd cycle -> flush=1, redirect_pc=0x180, stall=0 that cycle; no ex_mc_done; FSM idle next cycle.
6. Back-to-back: start L=2, then a new start in the DONE cycle with L=2 -> done pulse, then 2 more stall cycles, then a second done.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush controller.
// Stall vectors, multi-cycle FSM states and legacy constants.
package pipeline_ctrl_pkg;

  localparam logic       RstEnable = 1'b1;
  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;

  typedef enum logic [1:0] {
    MC_IDLE = 2'd0,
    MC_BUSY = 2'd1,
    MC_DONE = 2'd2
  } mc_state_e;

endpackage

// File: rtl/pipeline_ctrl_mc_stall_timer.sv
// Holds EX for the length of a multi-cycle op.
// Flags the result in the cycle after the last hold cycle.
module pipeline_ctrl_mc_stall_timer
  import pipeline_ctrl_pkg::*;
#(
  parameter int MC_CNT_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [MC_CNT_W-1:0] len,
  input  logic                abort,
  output logic                mc_stall,
  output logic                ex_mc_done
);

  mc_state_e           state;
  mc_state_e           state_n;
  logic [MC_CNT_W-1:0] cnt;
  logic [MC_CNT_W-1:0] cnt_n;
  logic                go;

  assign go = start && !abort && (len != '0);

  // State and remaining-hold counter registers.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state <= MC_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next state, counter update and hold request.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    mc_stall = 1'b0;
    unique case (state)
      MC_IDLE, MC_DONE: begin
        state_n = MC_IDLE;
        if (go) begin
          mc_stall = 1'b1;
          if (len == MC_CNT_W'(1)) begin
            state_n = MC_DONE;
          end else begin
            state_n = MC_BUSY;
            cnt_n   = len - MC_CNT_W'(2);
          end
        end
      end
      MC_BUSY: begin
        mc_stall = 1'b1;
        if (cnt == '0) begin
          state_n = MC_DONE;
        end else begin
          cnt_n = cnt - MC_CNT_W'(1);
        end
      end
      default: begin
        state_n = MC_IDLE;
        cnt_n   = '0;
      end
    endcase
    if (abort) begin
      state_n = MC_IDLE;
      cnt_n   = '0;
    end
  end

  assign ex_mc_done = (state == MC_DONE);

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Exception > multi-cycle hold > load-use > taken branch.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int PC_W     = 32,
  parameter int MC_CNT_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_stallreq,
  input  logic                id_branch_taken,
  input  logic [PC_W-1:0]     id_branch_target,
  input  logic                ex_mc_start,
  input  logic [MC_CNT_W-1:0] ex_mc_len,
  input  logic                mem_excp,
  input  logic [PC_W-1:0]     mem_excp_vector,
  output logic [5:0]          stall,
  output logic                flush,
  output logic                flush_if_id,
  output logic                pc_redirect,
  output logic [PC_W-1:0]     redirect_pc,
  output logic                ex_mc_done
);

  logic mc_stall;
  logic mc_done;
  logic in_rst;

  assign in_rst = (rst == RstEnable);

  pipeline_ctrl_mc_stall_timer #(
    .MC_CNT_W(MC_CNT_W)
  ) u_mc_stall_timer (
    .clk       (clk),
    .rst       (rst),
    .start     (ex_mc_start),
    .len       (ex_mc_len),
    .abort     (mem_excp),
    .mc_stall  (mc_stall),
    .ex_mc_done(mc_done)
  );

  assign ex_mc_done = mc_done && !in_rst;

  // One event source drives the pipeline controls per cycle.
  always_comb begin
    stall       = STALL_NONE;
    flush       = 1'b0;
    flush_if_id = 1'b0;
    pc_redirect = 1'b0;
    redirect_pc = PC_W'(ZeroWord);
    priority case (1'b1)
      in_rst: begin
        stall = STALL_NONE;
      end
      mem_excp: begin
        flush       = 1'b1;
        flush_if_id = 1'b1;
        pc_redirect = 1'b1;
        redirect_pc = mem_excp_vector;
      end
      mc_stall: begin
        stall = STALL_EX;
      end
      id_stallreq: begin
        stall = STALL_ID;
      end
      id_branch_taken: begin
        flush_if_id = 1'b1;
        pc_redirect = 1'b1;
        redirect_pc = id_branch_target;
      end
      default: begin
        stall = STALL_NONE;
      end
    endcase
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl.
// Directed scenarios plus randomized traffic against a model.
module tb_pipeline_ctrl;

  logic        clk;
  logic        rst;
  logic        id_stallreq;
  logic        id_branch_taken;
  logic [31:0] id_branch_target;
  logic        ex_mc_start;
  logic [4:0]  ex_mc_len;
  logic        mem_excp;
  logic [31:0] mem_excp_vector;
  logic [5:0]  stall;
  logic        flush;
  logic        flush_if_id;
  logic        pc_redirect;
  logic [31:0] redirect_pc;
  logic        ex_mc_done;

  int checks   = 0;
  int failures = 0;

  // model: hold cycles still owed after this one, and done flag
  int left   = 0;
  bit done_q = 1'b0;

  pipeline_ctrl #(
    .PC_W    (32),
    .MC_CNT_W(5)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .id_stallreq     (id_stallreq),
    .id_branch_taken (id_branch_taken),
    .id_branch_target(id_branch_target),
    .ex_mc_start     (ex_mc_start),
    .ex_mc_len       (ex_mc_len),
    .mem_excp        (mem_excp),
    .mem_excp_vector (mem_excp_vector),
    .stall           (stall),
    .flush           (flush),
    .flush_if_id     (flush_if_id),
    .pc_redirect     (pc_redirect),
    .redirect_pc     (redirect_pc),
    .ex_mc_done      (ex_mc_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(string nm, logic [63:0] got,
                              logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endfunction

  // {stall, flush, flush_if_id, pc_redirect, redirect_pc, done}
  function automatic logic [41:0] model_out();
    logic       hold;
    logic [5:0] s;
    logic       f, fi, pr, d;
    logic [31:0] rp;
    s = 6'd0; f = 0; fi = 0; pr = 0; rp = 32'd0; d = 0;
    hold = (left > 0) || (ex_mc_start && ex_mc_len != 5'd0);
    if (!rst) begin
      d = done_q;
      if (mem_excp) begin
        f = 1; fi = 1; pr = 1; rp = mem_excp_vector;
      end else if (hold) begin
        s = 6'b001111;
      end else if (id_stallreq) begin
        s = 6'b000111;
      end else if (id_branch_taken) begin
        fi = 1; pr = 1; rp = id_branch_target;
      end
    end
    return {s, f, fi, pr, rp, d};
  endfunction

  // Model advance: counts owed hold cycles down to the done cycle.
  always @(posedge clk) begin
    if (rst || mem_excp) begin
      left   <= 0;
      done_q <= 1'b0;
    end else if (left > 0) begin
      left   <= left - 1;
      done_q <= (left == 1);
    end else if (ex_mc_start && ex_mc_len != 5'd0) begin
      left   <= int'(ex_mc_len) - 1;
      done_q <= (ex_mc_len == 5'd1);
    end else begin
      done_q <= 1'b0;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("cycle",
        {22'd0, stall, flush, flush_if_id, pc_redirect,
         redirect_pc, ex_mc_done},
        {22'd0, model_out()});
  end

  task automatic cyc(input bit r, input bit sr, input bit bt,
                     input logic [31:0] tg, input bit ms,
                     input logic [4:0] ml, input bit ex,
                     input logic [31:0] ev);
    @(posedge clk);
    #1;
    rst              = r;
    id_stallreq      = sr;
    id_branch_taken  = bt;
    id_branch_target = tg;
    ex_mc_start      = ms;
    ex_mc_len        = ml;
    mem_excp         = ex;
    mem_excp_vector  = ev;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 32'h0, 0, 5'd0, 0, 32'h0);
  endtask

  initial begin
    rst              = 1'b1;
    id_stallreq      = 1'b1;
    id_branch_taken  = 1'b1;
    id_branch_target = 32'hFFFF_FFFF;
    ex_mc_start      = 1'b1;
    ex_mc_len        = 5'd31;
    mem_excp         = 1'b1;
    mem_excp_vector  = 32'hFFFF_FFFF;

    // reset with every input high
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 1, 32'hFFFF_FFFF, 1, 5'd31, 1, 32'hFFFF_FFFF);
      chk("rst_stall", stall, 6'd0);
      chk("rst_flush", {flush, flush_if_id, pc_redirect}, 3'd0);
      chk("rst_rpc", redirect_pc, 32'd0);
      chk("rst_done", ex_mc_done, 1'b0);
    end
    idle();
    chk("post_rst_stall", stall, 6'd0);
    chk("post_rst_done", ex_mc_done, 1'b0);

    // L=4
    cyc(0, 0, 0, 32'h0, 1, 5'd4, 0, 32'h0);
    chk("l4_c1", stall, 6'b001111);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("l4_hold", stall, 6'b001111);
      chk("l4_nodone", ex_mc_done, 1'b0);
    end
    idle();
    chk("l4_done", ex_mc_done, 1'b1);
    chk("l4_free", stall, 6'd0);
    idle();
    chk("l4_done_clr", ex_mc_done, 1'b0);

    // L=1
    cyc(0, 0, 0, 32'h0, 1, 5'd1, 0, 32'h0);
    chk("l1_hold", stall, 6'b001111);
    idle();
    chk("l1_done", {stall, ex_mc_done}, {6'd0, 1'b1});

    // L=0 ignored
    cyc(0, 0, 0, 32'h0, 1, 5'd0, 0, 32'h0);
    chk("l0_stall", stall, 6'd0);
    idle();
    chk("l0_done", ex_mc_done, 1'b0);

    // L=31
    cyc(0, 0, 0, 32'h0, 1, 5'd31, 0, 32'h0);
    chk("l31_c1", stall, 6'b001111);
    for (int i = 0; i < 30; i++) begin
      idle();
      chk("l31_hold", {stall, ex_mc_done}, {6'b001111, 1'b0});
    end
    idle();
    chk("l31_done", {stall, ex_mc_done}, {6'd0, 1'b1});

    // load-use suppresses branch, then branch goes
    cyc(0, 1, 1, 32'h40, 0, 5'd0, 0, 32'h0);
    chk("lu_stall", stall, 6'b000111);
    chk("lu_nobr", pc_redirect, 1'b0);
    cyc(0, 0, 1, 32'h40, 0, 5'd0, 0, 32'h0);
    chk("br_redir", {pc_redirect, flush_if_id, flush}, 3'b110);
    chk("br_pc", redirect_pc, 32'h40);
    chk("br_stall", stall, 6'd0);

    // branch held under L=3
    cyc(0, 0, 1, 32'h100, 1, 5'd3, 0, 32'h0);
    chk("bmc_c1", {stall, pc_redirect}, {6'b001111, 1'b0});
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 1, 32'h100, 0, 5'd0, 0, 32'h0);
      chk("bmc_hold", {stall, pc_redirect}, {6'b001111, 1'b0});
    end
    cyc(0, 0, 1, 32'h100, 0, 5'd0, 0, 32'h0);
    chk("bmc_done", {ex_mc_done, pc_redirect}, 2'b11);
    chk("bmc_pc", redirect_pc, 32'h100);

    // exception aborts L=6
    cyc(0, 0, 0, 32'h0, 1, 5'd6, 0, 32'h0);
    idle();
    chk("ex_pre", stall, 6'b001111);
    cyc(0, 0, 0, 32'h0, 0, 5'd0, 1, 32'h180);
    chk("ex_flush", {flush, flush_if_id, pc_redirect}, 3'b111);
    chk("ex_pc", redirect_pc, 32'h180);
    chk("ex_stall", stall, 6'd0);
    for (int i = 0; i < 6; i++) begin
      idle();
      chk("ex_after", {stall, ex_mc_done}, 7'd0);
    end

    // back-to-back L=2
    cyc(0, 0, 0, 32'h0, 1, 5'd2, 0, 32'h0);
    chk("bb_c1", stall, 6'b001111);
    idle();
    chk("bb_c2", {stall, ex_mc_done}, {6'b001111, 1'b0});
    cyc(0, 0, 0, 32'h0, 1, 5'd2, 0, 32'h0);
    chk("bb_done1", {stall, ex_mc_done}, {6'b001111, 1'b1});
    idle();
    chk("bb_c4", {stall, ex_mc_done}, {6'b001111, 1'b0});
    idle();
    chk("bb_done2", {stall, ex_mc_done}, {6'd0, 1'b1});

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bit          r, sr, bt, ms, ex;
      logic [4:0]  ml;
      int unsigned pick;
      r    = ($urandom_range(99) == 0);
      ex   = ($urandom_range(29) == 0);
      sr   = ($urandom_range(3) == 0);
      bt   = ($urandom_range(2) == 0);
      ms   = (left == 0) ? ($urandom_range(3) == 0)
                         : ($urandom_range(19) == 0);
      pick = $urandom_range(4);
      case (pick)
        0: ml = 5'd0;
        1: ml = 5'd1;
        2: ml = 5'd2;
        3: ml = 5'd31;
        default: ml = 5'($urandom_range(31));
      endcase
      cyc(r, sr, bt, $urandom, ms, ml, ex, $urandom);
    end

    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
